// File: rtl/pipeline_exu_stage.sv
// pipeline_exu_stage
//   Execute stage of the in-order RISC-V pipeline, between EXB (branch) and
//   the memory stage. ALU operations complete in one cycle. M-extension
//   operations (including the W forms on XLEN=64) go through an iterative
//   shift-add multiplier or a restoring divider. Divide-by-zero and signed
//   overflow bypass the iteration and finish in one cycle.
//
//   Ports
//     clk, reset (async, active-low)
//     stall      : downstream hold, EXA registers keep their value
//     flush      : abort any in-flight M op, EXA receives a bubble
//     *_EXB      : instruction, operands and sideband from the EXB stage
//     busy       : upstream must hold the EXB inputs constant
//     *_EXA      : registered results and sideband for the memory stage
//
//   ALU control encoding (alu_ctrl_EXB):
//     0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND,
//     10 pass operand B, others 0
module pipeline_exu_stage #(
  parameter int XLEN     = 64,
  parameter int MUL_FAST = 0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            valid_EXB,
  input  logic [XLEN-1:0] reg_data1_EXB,
  input  logic [XLEN-1:0] reg_data2_EXB,
  input  logic [XLEN-1:0] imm_EXB,
  input  logic [XLEN-1:0] pc_EXB,
  input  logic [4:0]      rd_EXB,
  input  logic            rf_wr_en_EXB,
  input  logic [1:0]      rf_wr_sel_EXB,
  input  logic [3:0]      alu_ctrl_EXB,
  input  logic            alu_a_sel_EXB,
  input  logic            alu_b_sel_EXB,
  input  logic            m_en_EXB,
  input  logic [2:0]      m_op_EXB,
  input  logic            m_word_EXB,
  input  logic [2:0]      dm_rd_ctrl_EXB,
  input  logic [2:0]      dm_wr_ctrl_EXB,
  output logic            busy,
  output logic            valid_EXA,
  output logic            rf_wr_en_EXA,
  output logic [1:0]      rf_wr_sel_EXA,
  output logic [4:0]      rd_EXA,
  output logic [XLEN-1:0] pc_EXA,
  output logic [XLEN-1:0] alu_result_EXA,
  output logic [XLEN-1:0] reg_data2_EXA,
  output logic [2:0]      dm_rd_ctrl_EXA,
  output logic [2:0]      dm_wr_ctrl_EXA
);

  localparam int W2 = 2 * XLEN;
  localparam int CW = $clog2(XLEN + 1);
  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [W2-1:0]   acc;       // product accumulator / partial remainder
  logic [W2-1:0]   wa;        // shifted multiplicand / divisor
  logic [XLEN-1:0] wb;        // multiplier / dividend-then-quotient
  logic [XLEN-1:0] m_res;
  logic            neg_q, neg_r, m_word_q;
  logic [2:0]      m_op_q;

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sx);
    logic signed [31:0]     sv;
    logic signed [XLEN-1:0] r;
    sv = v;
    if (sx) r = XLEN'(sv);
    else    r = XLEN'(v);
    return r;
  endfunction

  function automatic logic [XLEN-1:0] alu_exec(input logic [3:0] ctrl,
                                               input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb;
    logic [SW-1:0]          sh;
    logic [XLEN-1:0]        res;
    sa = a;
    sb = b;
    sh = b[SW-1:0];
    case (ctrl)
      4'd0:    res = a + b;
      4'd1:    res = a - b;
      4'd2:    res = a << sh;
      4'd3:    res = XLEN'(sa < sb);
      4'd4:    res = XLEN'(a < b);
      4'd5:    res = a ^ b;
      4'd6:    res = a >> sh;
      4'd7:    res = sa >>> sh;
      4'd8:    res = a | b;
      4'd9:    res = a & b;
      4'd10:   res = b;
      default: res = '0;
    endcase
    return res;
  endfunction

  // Applies the recorded signs to the unsigned product/quotient/remainder,
  // picks the half or quantity the op wants, and narrows W results.
  function automatic logic [XLEN-1:0] m_finish(input logic [2:0]      op,
                                               input logic            word,
                                               input logic            nq,
                                               input logic            nr,
                                               input logic [W2-1:0]   prod,
                                               input logic [XLEN-1:0] quo,
                                               input logic [XLEN-1:0] rem);
    logic [W2-1:0]   p;
    logic [XLEN-1:0] res;
    p = nq ? -prod : prod;
    case (op)
      3'd0:             res = p[XLEN-1:0];
      3'd1, 3'd2, 3'd3: res = p[W2-1:XLEN];
      3'd4, 3'd5:       res = nq ? -quo : quo;
      default:          res = nr ? -rem : rem;
    endcase
    if (word) res = ext32(res[31:0], 1'b1);
    return res;
  endfunction

  logic [XLEN-1:0] op_a, op_b, a_mag, b_mag, min_neg, alu_out, one_res;
  logic            sgn_a, sgn_b, a_neg, b_neg, word_op, is_mul;
  logic            div_zero, div_ovf, special, fast_mul, start;
  logic [W2-1:0]   fast_prod;

  // ---- EXB: operand preparation, one-cycle results, start decision ----
  always_comb begin
    word_op   = (XLEN == 64) && m_word_EXB;
    sgn_a     = (m_op_EXB == 3'd1) || (m_op_EXB == 3'd2) ||
                (m_op_EXB == 3'd4) || (m_op_EXB == 3'd6);
    sgn_b     = (m_op_EXB == 3'd1) || (m_op_EXB == 3'd4) || (m_op_EXB == 3'd6);
    op_a      = word_op ? ext32(reg_data1_EXB[31:0], sgn_a) : reg_data1_EXB;
    op_b      = word_op ? ext32(reg_data2_EXB[31:0], sgn_b) : reg_data2_EXB;
    a_neg     = sgn_a & op_a[XLEN-1];
    b_neg     = sgn_b & op_b[XLEN-1];
    a_mag     = a_neg ? -op_a : op_a;
    b_mag     = b_neg ? -op_b : op_b;
    is_mul    = ~m_op_EXB[2];
    min_neg   = word_op ? ext32(32'h8000_0000, 1'b1) : {1'b1, {(XLEN-1){1'b0}}};
    div_zero  = ~is_mul & (op_b == '0);
    div_ovf   = ~is_mul & sgn_b & (op_a == min_neg) & (op_b == '1);
    special   = div_zero | div_ovf;
    fast_mul  = (MUL_FAST != 0) && is_mul;
    fast_prod = (MUL_FAST != 0) ? (W2'(a_mag) * W2'(b_mag)) : '0;
    start     = (state == S_IDLE) & valid_EXB & m_en_EXB & ~flush & ~special & ~fast_mul;
    busy      = ~flush & (start | (state == S_MUL) | (state == S_DIV) |
                          ((state == S_DONE) & stall));

    alu_out = alu_exec(alu_ctrl_EXB,
                       alu_a_sel_EXB ? reg_data1_EXB : pc_EXB,
                       alu_b_sel_EXB ? imm_EXB : reg_data2_EXB);
    if (!m_en_EXB)
      one_res = alu_out;
    else if (is_mul)
      one_res = m_finish(m_op_EXB, word_op, a_neg ^ b_neg, 1'b0, fast_prod, '0, '0);
    else
      one_res = m_finish(m_op_EXB, word_op, 1'b0, 1'b0, '0,
                         div_zero ? '1 : op_a, div_zero ? op_a : '0);
  end

  logic [XLEN:0]   rem_sh, rem_diff;
  logic            rem_ge;
  logic [W2-1:0]   acc_nx;
  logic [XLEN-1:0] wb_nx;

  // One multiply or divide iteration. The dividend is left-aligned in wb so
  // its MSB feeds the partial remainder while quotient bits enter at bit 0.
  always_comb begin
    rem_sh   = {acc[XLEN-1:0], wb[XLEN-1]};
    rem_diff = rem_sh - {1'b0, wa[XLEN-1:0]};
    rem_ge   = rem_sh >= {1'b0, wa[XLEN-1:0]};
    if (state == S_MUL) begin
      acc_nx = acc + (wb[0] ? wa : '0);
      wb_nx  = wb >> 1;
    end else begin
      acc_nx = W2'(rem_ge ? rem_diff : rem_sh);
      wb_nx  = {wb[XLEN-2:0], rem_ge};
    end
  end

  // ---- iterative M unit ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      wa       <= '0;
      wb       <= '0;
      m_res    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      m_op_q   <= '0;
      m_word_q <= 1'b0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          state    <= is_mul ? S_MUL : S_DIV;
          cnt      <= word_op ? CW'(32) : CW'(XLEN);
          acc      <= '0;
          wa       <= W2'(is_mul ? a_mag : b_mag);
          wb       <= is_mul ? b_mag : (word_op ? (a_mag << (XLEN - 32)) : a_mag);
          neg_q    <= a_neg ^ b_neg;
          neg_r    <= a_neg;
          m_op_q   <= m_op_EXB;
          m_word_q <= word_op;
        end
        S_MUL, S_DIV: begin
          acc <= acc_nx;
          wb  <= wb_nx;
          cnt <= cnt - CW'(1);
          if (state == S_MUL) wa <= wa << 1;
          if (cnt == CW'(1)) begin
            state <= S_DONE;
            m_res <= m_finish(m_op_q, m_word_q, neg_q, neg_r, acc_nx, wb_nx, acc_nx[XLEN-1:0]);
          end
        end
        S_DONE:  if (!stall) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // ---- EXA output registers ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_EXA      <= 1'b0;
      rf_wr_en_EXA   <= 1'b0;
      rf_wr_sel_EXA  <= '0;
      rd_EXA         <= '0;
      pc_EXA         <= '0;
      alu_result_EXA <= '0;
      reg_data2_EXA  <= '0;
      dm_rd_ctrl_EXA <= '0;
      dm_wr_ctrl_EXA <= '0;
    end else if (!stall) begin
      if (flush || start || state == S_MUL || state == S_DIV) begin
        valid_EXA      <= 1'b0;
        rf_wr_en_EXA   <= 1'b0;
        dm_rd_ctrl_EXA <= '0;
        dm_wr_ctrl_EXA <= '0;
      end else begin
        valid_EXA      <= (state == S_DONE) ? 1'b1 : valid_EXB;
        alu_result_EXA <= (state == S_DONE) ? m_res : one_res;
        rf_wr_en_EXA   <= rf_wr_en_EXB;
        rf_wr_sel_EXA  <= rf_wr_sel_EXB;
        rd_EXA         <= rd_EXB;
        pc_EXA         <= pc_EXB;
        reg_data2_EXA  <= reg_data2_EXB;
        dm_rd_ctrl_EXA <= dm_rd_ctrl_EXB;
        dm_wr_ctrl_EXA <= dm_wr_ctrl_EXB;
      end
    end
  end

endmodule
